cfc_unit: RTL and testbench



---
 rtl/cfc_pkg.sv | 35 +++
 rtl/cfc_mac.sv | 51 +++++
 rtl/cfc_unit.sv | 106 ++++++++++
 tb/tb_cfc_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cfc_pkg.sv
// Shared definitions for the cfc_unit MAC bank: sizes, opcodes, FSM states
// and the accumulator-to-byte clamp used when packing results.
package cfc_pkg;

    localparam int N_MAC  = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int IDX_W  = $clog2(N_MAC);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_MAC   = 2'd2;
    localparam logic [1:0] OP_GET   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Negative -> 0, anything above 255 -> 255, otherwise the low byte.
    // The sign bit and the bits above the byte decide this, so no wide compare is needed.
    function automatic logic [DATA_W-1:0] clamp_byte(input logic signed [ACC_W-1:0] acc);
        logic [DATA_W-1:0] res;
        if (acc[ACC_W-1]) begin
            res = '0;
        end else if (|acc[ACC_W-2:DATA_W]) begin
            res = '1;
        end else begin
            res = acc[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/cfc_mac.sv
// One signed accumulator: acc += unsigned pixel * signed coefficient.
// The sum wraps modulo 2^ACC_W; clear has priority over enable.
module cfc_mac
    import cfc_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear_i,
    input  logic                     enable_i,
    input  logic [DATA_W-1:0]        value_a_i,
    input  logic [DATA_W-1:0]        value_b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int PROD_W = 2 * DATA_W + 1;

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // Operands widened to the product width so the multiply is exact and signed.
    assign a_ext    = {{DATA_W{1'b0}}, 1'b0, value_a_i};
    assign b_ext    = {{(DATA_W + 1){value_b_i[DATA_W-1]}}, value_b_i};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Next accumulator value.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (enable_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    // Accumulator register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cfc_unit.sv
// Four-channel MAC bank behind a 2-bit opcode interface.
//   state   | meaning
//   IDLE    | waiting for first command after reset
//   EXEC    | performing the latched command (one cycle, inputs ignored)
//   DONE    | command finished, done=1 until the next command is accepted
module cfc_unit
    import cfc_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [1:0]                op_code,
    input  logic [IDX_W-1:0]          index,
    input  logic [DATA_W-1:0]         value_a,
    input  logic [DATA_W-1:0]         value_b,
    output logic [N_MAC*DATA_W-1:0]   data_out,
    output logic                      done
);

    state_e                    state_q, state_d;
    logic [1:0]                op_q;
    logic [IDX_W-1:0]          idx_q;
    logic [DATA_W-1:0]         a_q;
    logic [DATA_W-1:0]         b_q;
    logic [N_MAC*DATA_W-1:0]   data_out_q;
    logic [N_MAC*DATA_W-1:0]   packed_w;
    logic                      accept;
    logic                      exec_clear;
    logic                      exec_mac;
    logic                      exec_get;
    logic signed [ACC_W-1:0]   acc [N_MAC];

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (op_code != OP_NOP) state_d = ST_EXEC;
            ST_EXEC:          state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: command acceptance, per-command strobes during EXEC, done flag.
    always_comb begin
        accept     = (state_q != ST_EXEC) && (op_code != OP_NOP);
        exec_clear = (state_q == ST_EXEC) && (op_q == OP_CLEAR);
        exec_mac   = (state_q == ST_EXEC) && (op_q == OP_MAC);
        exec_get   = (state_q == ST_EXEC) && (op_q == OP_GET);
        done       = (state_q == ST_DONE);
    end

    // Command latch, loaded only on the accepting edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= OP_NOP;
            idx_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (accept) begin
            op_q  <= op_code;
            idx_q <= index;
            a_q   <= value_a;
            b_q   <= value_b;
        end
    end

    for (genvar i = 0; i < N_MAC; i++) begin : g_mac
        cfc_mac u_mac (
            .clock     (clock),
            .reset_n   (reset_n),
            .clear_i   (exec_clear),
            .enable_i  (exec_mac && (idx_q == IDX_W'(i))),
            .value_a_i (a_q),
            .value_b_i (b_q),
            .acc_o     (acc[i])
        );
    end

    // Clamp every channel to a byte and pack channel 0 into the low byte.
    always_comb begin
        packed_w = '0;
        for (int i = 0; i < N_MAC; i++) begin
            packed_w[i*DATA_W +: DATA_W] = clamp_byte(acc[i]);
        end
    end

    // Result register, refreshed only by GET.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= '0;
        end else if (exec_get) begin
            data_out_q <= packed_w;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_cfc_unit.sv
// Bench for cfc_unit: a vector table of commands with hand-computed expected
// GET words, a scoreboard queue for GET results, and hand sequences for the
// EXEC-time corner cases (ignored opcode, reset mid-command, accumulator wrap).
module tb_cfc_unit;
    import cfc_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  op_code;
    logic [1:0]  index;
    logic [7:0]  value_a;
    logic [7:0]  value_b;
    logic [31:0] data_out;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_dout;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    cfc_unit dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .op_code  (op_code),
        .index    (index),
        .value_a  (value_a),
        .value_b  (value_b),
        .data_out (data_out),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one command at the current cycle (caller is #1 after a rising edge).
    // noise=1 keeps a nonzero opcode on the bus during EXEC, which must be ignored.
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] idx, input logic [7:0] a,
                          input logic [7:0] b, input logic [31:0] exp, input bit noise,
                          input string name);
        int cyc;
        op_code = op;
        index   = idx;
        value_a = a;
        value_b = b;
        if (op == OP_GET) exp_q.push_back(exp);
        @(posedge clock); #1;
        check32({name, "_accept_done"}, {31'd0, done}, 32'd0);
        if (noise) begin
            op_code = OP_MAC;
            index   = 2'd0;
            value_a = 8'd7;
            value_b = 8'd1;
        end else begin
            op_code = OP_NOP;
        end
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
        end while (!done && cyc < 5);
        op_code = OP_NOP;
        check32({name, "_latency"}, 32'(cyc), 32'd1);
        if (op == OP_GET) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_scoreboard: got empty queue expected entry", name);
            end else begin
                exp_dout = exp_q.pop_front();
            end
        end
        check32({name, "_data_out"}, data_out, exp_dout);
    endtask

    initial begin
        vecs[0]  = '{OP_CLEAR, 2'd0, 8'd0,   8'd0,   32'h0000_0000};
        vecs[1]  = '{OP_GET,   2'd0, 8'd0,   8'd0,   32'h0000_0000};
        vecs[2]  = '{OP_MAC,   2'd0, 8'd10,  8'd1,   32'h0};
        vecs[3]  = '{OP_MAC,   2'd1, 8'd20,  8'd1,   32'h0};
        vecs[4]  = '{OP_MAC,   2'd2, 8'd30,  8'd1,   32'h0};
        vecs[5]  = '{OP_MAC,   2'd3, 8'd40,  8'd1,   32'h0};
        vecs[6]  = '{OP_GET,   2'd0, 8'd0,   8'd0,   32'h281E_140A};
        vecs[7]  = '{OP_CLEAR, 2'd0, 8'd0,   8'd0,   32'h0};
        vecs[8]  = '{OP_MAC,   2'd0, 8'd100, 8'd2,   32'h0};
        vecs[9]  = '{OP_MAC,   2'd0, 8'd50,  8'hFF,  32'h0};
        vecs[10] = '{OP_MAC,   2'd1, 8'd10,  8'hFB,  32'h0};
        vecs[11] = '{OP_MAC,   2'd2, 8'd255, 8'd127, 32'h0};
        vecs[12] = '{OP_GET,   2'd0, 8'd0,   8'd0,   32'h00FF_0096};
        vecs[13] = '{OP_CLEAR, 2'd0, 8'd0,   8'd0,   32'h0};
        vecs[14] = '{OP_MAC,   2'd3, 8'd255, 8'd1,   32'h0};
        vecs[15] = '{OP_MAC,   2'd1, 8'd128, 8'd2,   32'h0};
        vecs[16] = '{OP_MAC,   2'd2, 8'd1,   8'hFF,  32'h0};
        vecs[17] = '{OP_GET,   2'd0, 8'd0,   8'd0,   32'hFF00_FF00};
        vecs[18] = '{OP_CLEAR, 2'd0, 8'd0,   8'd0,   32'h0};
        vecs[19] = '{OP_GET,   2'd0, 8'd0,   8'd0,   32'h0000_0000};

        exp_dout = 32'h0;
        reset_n  = 1'b0;
        op_code  = OP_NOP;
        index    = 2'd0;
        value_a  = 8'd0;
        value_b  = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check32("reset_done", {31'd0, done}, 32'd0);
        check32("reset_data_out", data_out, 32'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check32("idle_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            do_cmd(vecs[i].op, vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0,
                   $sformatf("vec%0d", i));
        end

        // done and data_out hold through idle cycles.
        repeat (3) @(posedge clock);
        #1;
        check32("hold_done", {31'd0, done}, 32'd1);
        check32("hold_data_out", data_out, exp_dout);

        // Accumulator wrap: 16 x 32385 still fits, the 17th wraps negative.
        do_cmd(OP_CLEAR, 2'd0, 8'd0, 8'd0, 32'h0, 1'b0, "wrap_clear");
        for (int k = 0; k < 16; k++) begin
            do_cmd(OP_MAC, 2'd0, 8'd255, 8'd127, 32'h0, 1'b0, $sformatf("wrap_mac%0d", k));
        end
        do_cmd(OP_GET, 2'd0, 8'd0, 8'd0, 32'h0000_00FF, 1'b0, "wrap_get16");
        do_cmd(OP_MAC, 2'd0, 8'd255, 8'd127, 32'h0, 1'b0, "wrap_mac16");
        do_cmd(OP_GET, 2'd0, 8'd0, 8'd0, 32'h0000_0000, 1'b0, "wrap_get17");

        // A nonzero opcode during EXEC must not be taken as a second command.
        do_cmd(OP_CLEAR, 2'd0, 8'd0, 8'd0, 32'h0, 1'b0, "noise_clear");
        do_cmd(OP_MAC, 2'd0, 8'd5, 8'd1, 32'h0, 1'b1, "noise_mac");
        do_cmd(OP_GET, 2'd0, 8'd0, 8'd0, 32'h0000_0005, 1'b1, "noise_get");

        // Reset during EXEC clears outputs immediately and aborts the MAC.
        op_code = OP_MAC;
        index   = 2'd1;
        value_a = 8'd9;
        value_b = 8'd1;
        @(posedge clock); #1;
        op_code = OP_NOP;
        reset_n = 1'b0;
        #1;
        check32("rst_exec_done", {31'd0, done}, 32'd0);
        check32("rst_exec_data_out", data_out, 32'h0);
        exp_dout = 32'h0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check32("rst_after_done", {31'd0, done}, 32'd0);
        do_cmd(OP_GET, 2'd0, 8'd0, 8'd0, 32'h0000_0000, 1'b0, "rst_get");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
